// File: rtl/fdas_calbus_pkg.sv
// rtl/fdas_calbus_pkg.sv - shared widths, constants and commit state type for the calibration bus responder
// Contents: bus/table widths, out-of-range read pattern, commit state enum.

package fdas_calbus_pkg;

    localparam int CALBUS_ADDR_W    = 20;
    localparam int CALBUS_DATA_W    = 32;
    localparam int CALBUS_TBL_W     = 4096;
    localparam int CALBUS_TBL_WORDS = 128;

    // Returned for any read that cannot be served from the register bank.
    localparam logic [CALBUS_DATA_W-1:0] CALBUS_BAD_DATA = 32'hBADC0DE5;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } commit_state_e;

endpackage

// File: rtl/fdas_calbus_rd_pipe.sv
// rtl/fdas_calbus_rd_pipe.sv - fixed-latency read data/valid pipeline with holding output stage
// Ports: clk_i/rst_i clock and async reset; in_valid_i/in_data_i sampled read;
//        rdata_o last matured result (held); empty_o no read in flight.

module fdas_calbus_rd_pipe #(
    parameter int LAT    = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              empty_o
);

    logic [LAT-1:0]    vld_q;
    logic [DATA_W-1:0] data_q [LAT];

    // Stage k is fed from stage k-1; index 0 of each chain is the bus input.
    logic [LAT:0]      vld_chain;
    logic [DATA_W-1:0] d_chain [LAT+1];

    assign vld_chain = {vld_q, in_valid_i};

    always_comb begin
        d_chain[0] = in_data_i;
        for (int k = 0; k < LAT; k++) begin
            d_chain[k+1] = data_q[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k] <= vld_chain[k];
                // The last stage is the bus output: it only loads a valid
                // result so the previous value is held between reads.
                if (k < LAT - 1 || vld_chain[k]) begin
                    data_q[k] <= d_chain[k];
                end
            end
        end
    end

    assign rdata_o = data_q[LAT-1];
    assign empty_o = ~|vld_q;

endmodule

// File: rtl/fdas_calbus_responder.sv
// rtl/fdas_calbus_responder.sv - calibration bus register target with double-buffered parameter table
// Ports: calbus_clk/calbus_rst clock and async reset; calbus_read/write/address/wdata/rdata target bus;
//        calbus_seq_param_tbl active table; tbl_wr_en/idx/data staging write; tbl_commit/tbl_busy copy;
//        err_clr/err_sticky error flag; stat_rd_cnt/stat_wr_cnt saturating access counters.

module fdas_calbus_responder
    import fdas_calbus_pkg::*;
#(
    parameter logic [CALBUS_ADDR_W-1:0] BASE_ADDR  = 20'h00000,
    parameter int                       NUM_REGS   = 64,
    parameter int                       RD_LATENCY = 2
) (
    input  logic                     calbus_clk,
    input  logic                     calbus_rst,
    input  logic                     calbus_read,
    input  logic                     calbus_write,
    input  logic [CALBUS_ADDR_W-1:0] calbus_address,
    input  logic [CALBUS_DATA_W-1:0] calbus_wdata,
    output logic [CALBUS_DATA_W-1:0] calbus_rdata,
    output logic [CALBUS_TBL_W-1:0]  calbus_seq_param_tbl,
    input  logic                     tbl_wr_en,
    input  logic [6:0]               tbl_wr_idx,
    input  logic [CALBUS_DATA_W-1:0] tbl_wr_data,
    input  logic                     tbl_commit,
    output logic                     tbl_busy,
    input  logic                     err_clr,
    output logic                     err_sticky,
    output logic [15:0]              stat_rd_cnt,
    output logic [15:0]              stat_wr_cnt
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [CALBUS_DATA_W-1:0] bank_q [NUM_REGS];
    logic [CALBUS_TBL_W-1:0]  stg_q, stg_d;
    logic [CALBUS_TBL_W-1:0]  act_q;
    logic [15:0]              rd_cnt_q, rd_cnt_d;
    logic [15:0]              wr_cnt_q, wr_cnt_d;
    logic                     err_q, err_d;
    commit_state_e            state_q, state_d;
    logic                     copy_go;

    logic                     in_range;
    logic [IDX_W-1:0]         reg_idx;
    logic [CALBUS_DATA_W-1:0] rd_sample;
    logic                     pipe_empty;
    logic                     err_set;

    assign in_range = calbus_address[CALBUS_ADDR_W-1:IDX_W] == BASE_ADDR[CALBUS_ADDR_W-1:IDX_W];
    assign reg_idx  = calbus_address[IDX_W-1:0];

    // A read colliding with a write is a protocol error and never returns bank data.
    assign rd_sample = (in_range && !calbus_write) ? bank_q[reg_idx] : CALBUS_BAD_DATA;
    assign err_set   = (calbus_read && (!in_range || calbus_write)) || (calbus_write && !in_range);

    fdas_calbus_rd_pipe #(
        .LAT    (RD_LATENCY),
        .DATA_W (CALBUS_DATA_W)
    ) u_rd_pipe (
        .clk_i      (calbus_clk),
        .rst_i      (calbus_rst),
        .in_valid_i (calbus_read),
        .in_data_i  (rd_sample),
        .rdata_o    (calbus_rdata),
        .empty_o    (pipe_empty)
    );

    always_ff @(posedge calbus_clk or posedge calbus_rst) begin
        if (calbus_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (calbus_write && in_range) begin
            bank_q[reg_idx] <= calbus_wdata;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        stg_d    = stg_q;
        if (calbus_read && rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (calbus_write && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        // A new error outranks a clear in the same cycle.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
        if (tbl_wr_en) begin
            stg_d[{tbl_wr_idx, 5'b0} +: CALBUS_DATA_W] = tbl_wr_data;
        end
    end

    // The copy waits until no read is in flight or being accepted, so a read
    // never straddles a table change.
    always_comb begin
        state_d = state_q;
        copy_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (tbl_commit) begin
                    if (pipe_empty && !calbus_read) begin
                        copy_go = 1'b1;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (pipe_empty && !calbus_read) begin
                    copy_go = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge calbus_clk or posedge calbus_rst) begin
        if (calbus_rst) begin
            stg_q    <= '0;
            act_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            stg_q    <= stg_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
            state_q  <= state_d;
            // stg_d already carries this cycle's staging write.
            if (copy_go) begin
                act_q <= stg_d;
            end
        end
    end

    assign calbus_seq_param_tbl = act_q;
    assign tbl_busy             = (state_q == PEND);
    assign err_sticky           = err_q;
    assign stat_rd_cnt          = rd_cnt_q;
    assign stat_wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_fdas_calbus_responder.sv
// tb/tb_fdas_calbus_responder.sv - scoreboard bench for fdas_calbus_responder

module tb_fdas_calbus_responder;

    localparam logic [19:0] T_BASE = 20'h001C0;
    localparam int          T_NREG = 64;
    localparam int          T_LAT  = 2;
    localparam logic [31:0] BAD    = 32'hBADC0DE5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          calbus_read = 1'b0;
    logic          calbus_write = 1'b0;
    logic [19:0]   calbus_address = '0;
    logic [31:0]   calbus_wdata = '0;
    logic [31:0]   calbus_rdata;
    logic [4095:0] calbus_seq_param_tbl;
    logic          tbl_wr_en = 1'b0;
    logic [6:0]    tbl_wr_idx = '0;
    logic [31:0]   tbl_wr_data = '0;
    logic          tbl_commit = 1'b0;
    logic          tbl_busy;
    logic          err_clr = 1'b0;
    logic          err_sticky;
    logic [15:0]   stat_rd_cnt;
    logic [15:0]   stat_wr_cnt;

    fdas_calbus_responder #(
        .BASE_ADDR  (T_BASE),
        .NUM_REGS   (T_NREG),
        .RD_LATENCY (T_LAT)
    ) dut (
        .calbus_clk           (clk),
        .calbus_rst           (rst),
        .calbus_read          (calbus_read),
        .calbus_write         (calbus_write),
        .calbus_address       (calbus_address),
        .calbus_wdata         (calbus_wdata),
        .calbus_rdata         (calbus_rdata),
        .calbus_seq_param_tbl (calbus_seq_param_tbl),
        .tbl_wr_en            (tbl_wr_en),
        .tbl_wr_idx           (tbl_wr_idx),
        .tbl_wr_data          (tbl_wr_data),
        .tbl_commit           (tbl_commit),
        .tbl_busy             (tbl_busy),
        .err_clr              (err_clr),
        .err_sticky           (err_sticky),
        .stat_rd_cnt          (stat_rd_cnt),
        .stat_wr_cnt          (stat_wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t   sb_q [$];
    int          edge_n = 0;
    int          checks = 0;
    int          failures = 0;

    // Reference model state: what the DUT should hold after the next edge.
    logic [31:0] regs_m [T_NREG];
    logic [31:0] stg_m [128];
    logic [31:0] act_m [128];
    logic [15:0] rd_cnt_m = '0;
    logic [15:0] wr_cnt_m = '0;
    bit          err_m = 1'b0;
    bit          pend_m = 1'b0;
    bit          have_rd = 1'b0;
    int          last_rd = 0;
    logic [31:0] held = '0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h edge=%0d", nm, got, exp, edge_n);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < T_NREG; i++) regs_m[i] = '0;
        for (int i = 0; i < 128; i++) begin
            stg_m[i] = '0;
            act_m[i] = '0;
        end
        rd_cnt_m = '0;
        wr_cnt_m = '0;
        err_m    = 1'b0;
        pend_m   = 1'b0;
        have_rd  = 1'b0;
        last_rd  = 0;
    endtask

    // Monitor: retire matured reads from the scoreboard, then compare all outputs.
    always @(posedge clk) begin
        sb_entry_t e;
        int bad_w;
        #1;
        if (rst) begin
            sb_q.delete();
            held = '0;
        end else if (sb_q.size() > 0 && sb_q[0].due == edge_n) begin
            e = sb_q.pop_front();
            held = e.data;
        end
        chk("rdata", calbus_rdata, held);
        chk("err_sticky", {31'b0, err_sticky}, {31'b0, err_m});
        chk("stat_rd_cnt", {16'b0, stat_rd_cnt}, {16'b0, rd_cnt_m});
        chk("stat_wr_cnt", {16'b0, stat_wr_cnt}, {16'b0, wr_cnt_m});
        chk("tbl_busy", {31'b0, tbl_busy}, {31'b0, pend_m});
        bad_w = -1;
        for (int w = 127; w >= 0; w--) begin
            if (calbus_seq_param_tbl[w*32 +: 32] !== act_m[w]) bad_w = w;
        end
        checks++;
        if (bad_w >= 0) begin
            failures++;
            $display("FAIL tbl word=%0d got=%h exp=%h edge=%0d", bad_w,
                     calbus_seq_param_tbl[bad_w*32 +: 32], act_m[bad_w], edge_n);
        end
    end

    // One bus cycle: drive inputs and advance the model to the post-edge state.
    task automatic drive(input bit rd, input bit wr, input logic [19:0] addr, input logic [31:0] wd,
                         input bit twe, input logic [6:0] tidx, input logic [31:0] td,
                         input bit cm, input bit ec);
        int  k;
        int  idx;
        bit  in_rng;
        bit  inflight;
        bit  set_err;
        @(negedge clk);
        calbus_read    = rd;
        calbus_write   = wr;
        calbus_address = addr;
        calbus_wdata   = wd;
        tbl_wr_en      = twe;
        tbl_wr_idx     = tidx;
        tbl_wr_data    = td;
        tbl_commit     = cm;
        err_clr        = ec;
        k        = edge_n;
        in_rng   = (int'(addr) / T_NREG) == (int'(T_BASE) / T_NREG);
        idx      = int'(addr) % T_NREG;
        // A read accepted at edge r occupies the pipeline until edge r+LAT.
        inflight = have_rd && (last_rd >= k - T_LAT + 1);
        if (rd) begin
            e_push(k + T_LAT, (in_rng && !wr) ? regs_m[idx] : BAD);
            if (rd_cnt_m != 16'hFFFF) rd_cnt_m++;
            have_rd = 1'b1;
            last_rd = k + 1;
        end
        if (wr) begin
            if (in_rng) regs_m[idx] = wd;
            if (wr_cnt_m != 16'hFFFF) wr_cnt_m++;
        end
        set_err = (rd && (!in_rng || wr)) || (wr && !in_rng);
        if (set_err) err_m = 1'b1;
        else if (ec) err_m = 1'b0;
        if (twe) stg_m[tidx] = td;
        if (pend_m || cm) begin
            if (!inflight && !rd) begin
                act_m  = stg_m;
                pend_m = 1'b0;
            end else begin
                pend_m = 1'b1;
            end
        end
    endtask

    task automatic e_push(input int due, input logic [31:0] d);
        sb_entry_t e;
        e.due  = due;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic idle_op(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, '0, '0, 0, 0);
    endtask

    task automatic wr_op(input logic [19:0] a, input logic [31:0] d);
        drive(0, 1, a, d, 0, '0, '0, 0, 0);
    endtask

    task automatic rd_op(input logic [19:0] a);
        drive(1, 0, a, '0, 0, '0, '0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        calbus_read    = 1'b0;
        calbus_write   = 1'b0;
        tbl_wr_en      = 1'b0;
        tbl_commit     = 1'b0;
        err_clr        = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [19:0] a;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Write then read back on the next cycle.
        wr_op(T_BASE + 20'd3, 32'hA5A5_0001);
        rd_op(T_BASE + 20'd3);
        idle_op(3);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) wr_op(T_BASE + 20'(i), 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) rd_op(T_BASE + 20'(i));
        idle_op(3);

        // Decode error, clear alone, clear coincident with a new error.
        rd_op(T_BASE + 20'(T_NREG));
        idle_op(3);
        drive(0, 0, '0, '0, 0, '0, '0, 0, 1);
        idle_op(1);
        rd_op(20'hFFFFF);
        drive(0, 1, 20'h00000, 32'h1, 0, '0, '0, 0, 1);
        idle_op(2);

        // Commit deferred by an in-flight read.
        drive(0, 0, '0, '0, 1, 7'd127, 32'hDEADBEEF, 0, 0);
        rd_op(T_BASE + 20'd5);
        drive(0, 0, '0, '0, 0, '0, '0, 1, 0);
        drive(0, 0, '0, '0, 0, '0, '0, 1, 0);
        idle_op(4);

        // Commit with a staging write in the same cycle, pipeline idle.
        drive(0, 0, '0, '0, 1, 7'd0, 32'hCAFE0000, 1, 0);
        idle_op(2);

        // Simultaneous read and write.
        drive(1, 1, T_BASE + 20'd1, 32'h55, 0, '0, '0, 0, 0);
        rd_op(T_BASE + 20'd1);
        idle_op(3);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 9) < 8) ? T_BASE + 20'($urandom_range(0, T_NREG - 1))
                                           : 20'($urandom_range(0, 20'hFFFFF));
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, $urandom,
                  $urandom_range(0, 3) == 0, 7'($urandom_range(0, 127)), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end
        idle_op(4);

        // Counter saturation, then reset with a read in flight.
        do_reset();
        for (int i = 0; i < 65534; i++) wr_op(T_BASE + 20'(i % T_NREG), 32'(i));
        for (int i = 0; i < 3; i++) wr_op(T_BASE, 32'h77);
        rd_op(T_BASE + 20'd2);
        do_reset();
        idle_op(5);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdas_calbus_responder.md
Name: fdas_calbus_responder

Overview:
- Target-side model of the EMIF calibration component bus.
- Answers calbus_read/calbus_write from the calibration initiator using a register bank with fixed read latency.
- Drives the 4096-bit sequencer parameter table from a double-buffered staging store.
- Used in FDAS DDR bring-up and verification benches, and as a soft register target for the calibration port.

Parameters:
- BASE_ADDR, 20'h00000: base of the register window; must be aligned to NUM_REGS.
- NUM_REGS, 64: number of 32-bit registers; power of 2, range 4..1024.
- RD_LATENCY, 2: cycles from sampled calbus_read to valid calbus_rdata; range 1..4.

Ports:
- calbus_clk  in  1  calibration bus clock.
- calbus_rst  in  1  asynchronous reset, active-high.
- calbus_read  in  1  read strobe, one cycle per access.
- calbus_write  in  1  write strobe, one cycle per access.
- calbus_address  in  20  word address.
- calbus_wdata  in  32  write data.
- calbus_rdata  out  32  read data.
- calbus_seq_param_tbl  out  4096  active parameter table.
- tbl_wr_en  in  1  staging word write enable.
- tbl_wr_idx  in  7  staging word index; word i occupies bits [32i+31:32i].
- tbl_wr_data  in  32  staging word data.
- tbl_commit  in  1  request to copy staging into the active table.
- tbl_busy  out  1  commit pending.
- err_clr  in  1  clears err_sticky.
- err_sticky  out  1  protocol or decode error seen.
- stat_rd_cnt  out  16  accepted reads, saturating.
- stat_wr_cnt  out  16  accepted writes, saturating.

Behaviour:
- Reset: all outputs 0; register bank, staging store and active table all 0; read pipeline empty; pending commit cleared. Reset asserted mid-operation discards in-flight reads and any pending commit.
- Decode: in range when calbus_address[19:log2(NUM_REGS)] == BASE_ADDR[19:log2(NUM_REGS)]. Index is the low log2(NUM_REGS) bits.
- Write, in range: register updated at the clock edge; stat_wr_cnt increments.
- Write, out of range: ignored; err_sticky set; counter still increments.
- Read: bank sampled at the edge where calbus_read=1; data appears on calbus_rdata exactly RD_LATENCY cycles later.
  - calbus_rdata holds that value until the next read result matures.
  - Out-of-range reads return 32'hBADC0DE5 and set err_sticky.
  - stat_rd_cnt increments at acceptance.
- Back-to-back reads: one read may be issued every cycle; results emerge in order, one per cycle.
- Write followed by read of the same address on the next cycle returns the new data.
- calbus_read and calbus_write asserted together:
  - err_sticky set.
  - The write is performed.
  - The read is accepted and returns 32'hBADC0DE5.
  - Both counters increment.
- Counters saturate at 16'hFFFF and never wrap.
- Error flag: err_clr clears err_sticky next cycle. A new error in the same cycle as err_clr wins, so the flag stays 1.
- Staging: tbl_wr_en writes word tbl_wr_idx at the edge. It never alters calbus_seq_param_tbl directly.
- Commit state machine, states IDLE and PEND:
  - IDLE with tbl_commit, read pipeline empty, and no read this cycle: active table <= staging at the next edge; tbl_busy stays 0.
  - IDLE with tbl_commit while a read is in flight or accepted this cycle: go to PEND; tbl_busy=1.
  - PEND: copy on the first cycle the pipeline is empty and calbus_read=0, then return to IDLE.
  - Further tbl_commit while in PEND is absorbed.
  - A staging write in the same cycle as the copy is included in the copied table (write-through into the copy).
- The active table never changes while a read is in flight, so the initiator sees a coherent table for each access.

Decomposition:
- Package fdas_calbus_pkg holds:
  - CALBUS_ADDR_W=20, CALBUS_DATA_W=32, CALBUS_TBL_W=4096, CALBUS_TBL_WORDS=128.
  - CALBUS_BAD_DATA=32'hBADC0DE5.
  - Commit state enum {IDLE, PEND}.
- Sub-module fdas_calbus_rd_pipe: parameterised RD_LATENCY data and valid shift pipeline. Exposes a pipeline-empty flag used by the commit state machine.

Test Plan:
- Write 32'hA5A5_0001 to BASE+3, read BASE+3 next cycle (RD_LATENCY=2) -> calbus_rdata=32'hA5A50001 two cycles after the read; stat_wr_cnt=1, stat_rd_cnt=1.
- Four back-to-back reads of indices 0..3, previously written 0x10..0x13 -> rdata 0x10,0x11,0x12,0x13 on consecutive cycles starting at RD_LATENCY.
- Read address BASE+NUM_REGS -> rdata=32'hBADC0DE5, err_sticky=1; err_clr pulsed alone -> 0; err_clr coincident with a new bad access -> stays 1.
- Load staging word 127=32'hDEADBEEF, commit with a read in flight -> tbl_busy=1; table bits [4095:4064] still 0 until the pipeline drains, then 32'hDEADBEEF and tbl_busy=0.
- Simultaneous read and write to BASE+1 with wdata 0x55 -> register becomes 0x55, rdata=32'hBADC0DE5, err_sticky=1, both counters increment.
- Preload stat_wr_cnt to 16'hFFFE via 2^16-2 writes, do 3 more writes -> stat_wr_cnt=16'hFFFF; assert calbus_rst mid-read -> all outputs 0 and no stale rdata afterwards.
